// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad/display code space, result-emitter FSM states, digit-count helper.
// Latency: none (package only).
// Backpressure: not applicable.
package calc_pkg;

  // 5-bit code space shared by the keypad accumulator and the display writer.
  typedef enum logic [4:0] {
    COD_0     = 5'd0,
    COD_1     = 5'd1,
    COD_2     = 5'd2,
    COD_3     = 5'd3,
    COD_4     = 5'd4,
    COD_5     = 5'd5,
    COD_6     = 5'd6,
    COD_7     = 5'd7,
    COD_8     = 5'd8,
    COD_9     = 5'd9,
    COD_SUMA  = 5'd10,
    COD_RESTA = 5'd11,
    COD_MULT  = 5'd12,
    COD_DIV   = 5'd13,
    COD_ALMOH = 5'd15,
    COD_MENOS = 5'd16,
    COD_ERROR = 5'd17
  } codigo_t;

  // Result emitter states.
  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    CONVIERTE   = 3'd1,
    EMITE_SIGNO = 3'd2,
    EMITE       = 3'd3,
    FIN         = 3'd4
  } estado_t;

  // Smallest number of decimal digits whose range covers every ANCHO-bit magnitude.
  function automatic int n_dig_de(input int ancho);
    longint lim;
    longint pot;
    int     n;
    lim = (longint'(1) << ancho) - 1;
    pot = 1;
    n   = 0;
    for (int k = 0; k < 20; k++) begin
      if (pot <= lim) begin
        pot = pot * 10;
        n   = n + 1;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
// Latency: ANCHO cycles from cargar to listo; bcd then holds until the next cargar.
// Backpressure: none; the result simply stays registered until reloaded.
module bin_a_bcd
  import calc_pkg::*;
#(
  parameter int ANCHO = 20,
  parameter int N_DIG = n_dig_de(ANCHO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cargar,
  input  logic [ANCHO-1:0]     valor,
  output logic                 listo,
  output logic [4*N_DIG-1:0]   bcd
);

  localparam int CW = $clog2(ANCHO + 1);

  logic [ANCHO-1:0]   sr;
  logic [CW-1:0]      cnt;
  logic [4*N_DIG-1:0] ajuste;
  logic [4*N_DIG-1:0] bcd_sig;

  // Add 3 to every digit >= 5, then shift in the next magnitude bit MSB-first.
  always_comb begin
    ajuste = bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) ajuste[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_sig = (ajuste << 1) | {{(4*N_DIG-1){1'b0}}, sr[ANCHO-1]};
  end

  // Shift register, BCD accumulator and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (cargar) begin
      sr  <= valor;
      cnt <= CW'(ANCHO);
      bcd <= '0;
    end else if (cnt != '0) begin
      sr  <= sr << 1;
      cnt <= cnt - 1'b1;
      bcd <= bcd_sig;
    end
  end

  assign listo = (cnt == '0);

endmodule

// File: rtl/emisor_digitos_resultado.sv
// Turns a binary result into an MSB-first stream of digit codes (optional minus, or a lone 'E').
// Latency: first code valid ANCHO+1 cycles after inicio (1 cycle on the error path), then one code per cycle.
// Backpressure: valid/ready; a stalled code holds stable, next code follows a transfer with no bubble.
module emisor_digitos_resultado
  import calc_pkg::*;
#(
  parameter int ANCHO = 20,
  parameter int N_DIG = n_dig_de(ANCHO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic [ANCHO-1:0] valor,
  input  logic             negativo,
  input  logic             error,
  output logic [4:0]       digito,
  output logic             digito_valido,
  input  logic             digito_acepta,
  output logic             ocupado,
  output logic             fin
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  estado_t            estado, estado_d;
  logic [IW-1:0]      idx, idx_d, lider;
  logic               neg_r, neg_d, err_r, err_d;
  logic [4:0]         digito_d;
  logic               valido_d;
  logic               cargar, listo, transfer;
  logic [4*N_DIG-1:0] bcd;

  bin_a_bcd #(
    .ANCHO (ANCHO),
    .N_DIG (N_DIG)
  ) u_bin_a_bcd (
    .clk    (clk),
    .reset  (reset),
    .cargar (cargar),
    .valor  (valor),
    .listo  (listo),
    .bcd    (bcd)
  );

  function automatic logic [4:0] cod_de(input logic [4*N_DIG-1:0] b, input logic [IW-1:0] i);
    return {1'b0, b[4*int'(i) +: 4]};
  endfunction

  assign transfer = digito_valido & digito_acepta;

  // Index of the highest non-zero BCD digit; 0 when the whole value is zero so a single '0' is sent.
  always_comb begin
    lider = '0;
    for (int i = 1; i < N_DIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) lider = IW'(i);
    end
  end

  // Next state, next output register contents and capture of the request attributes.
  always_comb begin
    estado_d = estado;
    digito_d = digito;
    valido_d = digito_valido;
    idx_d    = idx;
    neg_d    = neg_r;
    err_d    = err_r;
    cargar   = 1'b0;
    case (estado)
      REPOSO: begin
        if (inicio) begin
          neg_d = negativo;
          err_d = error;
          if (error) begin
            estado_d = EMITE;
          end else begin
            cargar   = 1'b1;
            estado_d = CONVIERTE;
          end
        end
      end
      CONVIERTE: begin
        if (listo) begin
          valido_d = 1'b1;
          if (neg_r) begin
            estado_d = EMITE_SIGNO;
            digito_d = COD_MENOS;
          end else begin
            estado_d = EMITE;
            idx_d    = lider;
            digito_d = cod_de(bcd, lider);
          end
        end
      end
      EMITE_SIGNO: begin
        if (transfer) begin
          estado_d = EMITE;
          idx_d    = lider;
          digito_d = cod_de(bcd, lider);
        end
      end
      EMITE: begin
        if (err_r) begin
          // Error path arrives here with nothing presented yet.
          if (!digito_valido) begin
            digito_d = COD_ERROR;
            valido_d = 1'b1;
          end else if (transfer) begin
            valido_d = 1'b0;
            estado_d = FIN;
          end
        end else if (transfer) begin
          if (idx == '0) begin
            valido_d = 1'b0;
            estado_d = FIN;
          end else begin
            idx_d    = idx - 1'b1;
            digito_d = cod_de(bcd, idx - 1'b1);
          end
        end
      end
      FIN: begin
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
        valido_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= REPOSO;
      digito        <= '0;
      digito_valido <= 1'b0;
      idx           <= '0;
      neg_r         <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      estado        <= estado_d;
      digito        <= digito_d;
      digito_valido <= valido_d;
      idx           <= idx_d;
      neg_r         <= neg_d;
      err_r         <= err_d;
    end
  end

  assign ocupado = (estado != REPOSO) && (estado != FIN);
  assign fin     = (estado == FIN);

endmodule

// File: tb/tb_emisor_digitos_resultado.sv
// Bench for emisor_digitos_resultado: scoreboard of expected codes fed by a decimal reference model.
// Latency: checks first-code latency (21 cycles normal, 1 cycle error) and fin timing.
// Backpressure: consumer ready driven held-high, toggling or random.
module tb_emisor_digitos_resultado;

  localparam int FIN_MARK = 99;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [19:0] valor;
  logic        negativo;
  logic        error;
  logic [4:0]  digito;
  logic        digito_valido;
  logic        digito_acepta;
  logic        ocupado;
  logic        fin;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int modo_acepta = 0;

  bit         stall_prev = 0;
  bit         more_prev  = 0;
  logic [4:0] dig_prev   = '0;
  int         e_mon;

  emisor_digitos_resultado #(
    .ANCHO (20),
    .N_DIG (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inicio        (inicio),
    .valor         (valor),
    .negativo      (negativo),
    .error         (error),
    .digito        (digito),
    .digito_valido (digito_valido),
    .digito_acepta (digito_acepta),
    .ocupado       (ocupado),
    .fin           (fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nombre, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nombre, act, req, $time);
    end
  endtask

  // Reference model: decimal digits of the magnitude, most significant first, then an end marker.
  task automatic push_exp(input int unsigned v, input bit neg, input bit err);
    int          d[$];
    int unsigned t;
    if (err) begin
      exp_q.push_back(17);
    end else begin
      if (neg) exp_q.push_back(16);
      t = v;
      do begin
        d.push_front(int'(t % 10));
        t = t / 10;
      end while (t != 0);
      foreach (d[i]) exp_q.push_back(d[i]);
    end
    exp_q.push_back(FIN_MARK);
  endtask

  // Consumer ready pattern.
  initial begin
    digito_acepta = 1'b0;
    forever begin
      @(negedge clk);
      case (modo_acepta)
        0:       digito_acepta = 1'b1;
        1:       digito_acepta = ~digito_acepta;
        default: digito_acepta = 1'($urandom);
      endcase
    end
  end

  // Monitor: compares every transfer and every fin against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stall_prev = 0;
        more_prev  = 0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", int'(digito_valido), 1);
          chk("hold_code", int'(digito), int'(dig_prev));
        end
        if (more_prev) chk("no_bubble", int'(digito_valido), 1);
        more_prev = 0;
        if (digito_valido && digito_acepta) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_code actual=%0d required=none", digito);
          end else begin
            e_mon = exp_q.pop_front();
            chk("code", int'(digito), e_mon);
            more_prev = (exp_q.size() > 0) && (exp_q[0] != FIN_MARK);
          end
        end
        if (fin) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_fin actual=1 required=0");
          end else begin
            e_mon = exp_q.pop_front();
            chk("fin_order", e_mon, FIN_MARK);
          end
          chk("fin_ocupado", int'(ocupado), 0);
        end
        stall_prev = digito_valido && !digito_acepta;
        dig_prev   = digito;
      end
    end
  end

  task automatic wait_fin();
    bit visto;
    visto = 0;
    for (int k = 0; k < 400; k++) begin
      if (fin) begin
        visto = 1;
        break;
      end
      @(negedge clk);
    end
    if (!visto) chk("fin_timeout", 0, 1);
  endtask

  // Issue one request, optionally check first-code latency, then wait for fin.
  task automatic send(input int unsigned v, input bit neg, input bit err, input int exp_lat);
    int n;
    @(negedge clk);
    inicio   = 1'b1;
    valor    = v[19:0];
    negativo = neg;
    error    = err;
    push_exp(v, neg, err);
    @(negedge clk);
    inicio   = 1'b0;
    valor    = 20'($urandom);
    negativo = 1'($urandom);
    error    = 1'($urandom);
    for (n = 1; n <= 200; n++) begin
      if (digito_valido) break;
      @(negedge clk);
    end
    if (exp_lat >= 0) chk("latency", n - 1, exp_lat);
    wait_fin();
  endtask

  initial begin
    int unsigned v;
    bit          neg, err;
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    bit          neg, err;
    int          n;
    reset    = 1'b1;
    inicio   = 1'b0;
    valor    = '0;
    negativo = 1'b0;
    error    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digito", int'(digito), 0);
    chk("rst_valido", int'(digito_valido), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_fin", int'(fin), 0);
    reset = 1'b0;

    // Plain value with acepta held high.
    modo_acepta = 0;
    send(1234, 0, 0, 21);
    // Zero.
    send(0, 0, 0, 21);
    // Largest magnitude, negative, with acepta toggling.
    modo_acepta = 1;
    send(1048575, 1, 0, 21);
    // Error path.
    modo_acepta = 0;
    send(77, 1, 1, 1);

    // Requests while busy are ignored; inicio in the fin cycle is ignored, the next cycle is accepted.
    modo_acepta = 1;
    @(negedge clk);
    inicio = 1'b1; valor = 20'd4321; negativo = 1'b0; error = 1'b0;
    push_exp(4321, 0, 0);
    @(negedge clk);
    inicio = 1'b0;
    repeat (5) @(negedge clk);
    inicio = 1'b1; valor = 20'd999; negativo = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (digito_valido) break;
      @(negedge clk);
    end
    @(negedge clk);
    inicio = 1'b1; valor = 20'd7; error = 1'b1;
    @(negedge clk);
    inicio = 1'b0; error = 1'b0;
    wait_fin();
    inicio = 1'b1; valor = 20'd55; negativo = 1'b0; error = 1'b0;
    @(negedge clk);
    inicio = 1'b0;
    chk("fin_cycle_ignored", int'(ocupado), 0);
    inicio = 1'b1; valor = 20'd60;
    push_exp(60, 0, 0);
    @(negedge clk);
    inicio = 1'b0;
    chk("accept_after_fin", int'(ocupado), 1);
    wait_fin();

    // Reset in the middle of emission after two of four digits.
    modo_acepta = 0;
    @(negedge clk);
    inicio = 1'b1; valor = 20'd1234; negativo = 1'b0; error = 1'b0;
    push_exp(1234, 0, 0);
    @(negedge clk);
    inicio = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (exp_q.size() <= 3) break;
      @(negedge clk);
    end
    chk("two_digits_out", exp_q.size(), 3);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valido", int'(digito_valido), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_fin", int'(fin), 0);
    repeat (3) @(negedge clk);
    send(5, 0, 0, 21);

    // Randomized requests against the reference model.
    for (int t = 0; t < 25; t++) begin
      modo_acepta = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 1048575);
        default: v = ($urandom_range(0, 1) == 1) ? 1048575 : 0;
      endcase
      neg = 1'($urandom);
      err = ($urandom_range(0, 5) == 0);
      send(v, neg, err, err ? 1 : 21);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/emisor_digitos_resultado.md
Name: emisor_digitos_resultado

Overview:
Converts a binary calculation result into a most-significant-first stream of digit codes for the display/LCD writer. It is the inverse of the keypad operand accumulator: that block turns key events into binary operands, and this block turns a binary result back into digit events.
- Uses the same 5-bit code space as the keypad (0-9 digits), plus codes for minus and error.
- Sits between the ALU result register and the display driver.
- Uses a valid/ready handshake on the output.

Parameters:
- ANCHO, 20, width of magnitude input valor.
- N_DIG, 7, BCD digits held; must satisfy 10^N_DIG > 2^ANCHO-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inicio  in  1  one-cycle request to emit a result; honoured only when ocupado=0.
- valor  in  ANCHO  unsigned magnitude of result; sampled with inicio.
- negativo  in  1  result sign; sampled with inicio.
- error  in  1  result invalid (e.g. division by zero); sampled with inicio; has priority over negativo and valor.
- digito  out  5  code presented: 0-9 digit, 16 minus, 17 error 'E'.
- digito_valido  out  1  digito is valid.
- digito_acepta  in  1  consumer ready; a transfer occurs on a clk edge where valido=1 and acepta=1.
- ocupado  out  1  high from the cycle after accepted inicio until fin.
- fin  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values: digito=0, digito_valido=0, ocupado=0, fin=0; FSM=REPOSO; internal registers cleared. Reset mid-operation aborts immediately and drops any pending digit with no fin.
- FSM states: REPOSO, CONVIERTE, EMITE_SIGNO, EMITE, FIN.
  - REPOSO: inicio=1 captures valor, negativo and error, and sets ocupado at the next edge.
    - If error=1, go to EMITE with the single code 17.
    - Otherwise go to CONVIERTE.
  - CONVIERTE: shift-add-3 (double dabble), one input bit per cycle, exactly ANCHO cycles.
    - Then go to EMITE_SIGNO if negativo=1, else EMITE.
    - With inicio sampled at edge 0, digito_valido is high after edge ANCHO+1.
  - EMITE_SIGNO: present 16; on transfer go to EMITE.
  - EMITE: present the BCD digits from the highest non-zero digit down to digit 0.
    - Leading zeros are suppressed.
    - valor=0 emits a single '0'.
    - The error path emits only 17, never a sign.
  - FIN: after the last transfer, one cycle with fin=1 and ocupado=0, then REPOSO.
    - inicio is not accepted in the FIN cycle; it is accepted from the next cycle.
- Handshake rules:
  - While valido=1 and acepta=0, digito holds stable and valido stays high.
  - After each transfer the next code appears on the following cycle with no bubble; valido stays high.
  - Back-to-back transfers sustain one digit per cycle.
  - acepta is ignored while valido=0.
- inicio while ocupado=1 is ignored; there is no queue.
- Negative zero (negativo=1, valor=0) emits 16 then 0; the caller is responsible for avoiding it.
- Maximum output is 1048575, which emits 7 digits, 8 with a sign.
- Inputs are not required to stay stable after the inicio cycle.

Decomposition:
- Package calc_pkg holds:
  - key/output code constants: digits 0-9; operators 10-13 (existing); '#' 15; COD_MENOS=16; COD_ERROR=17.
  - FSM state encoding.
  - a function computing N_DIG from ANCHO.
- Natural sub-module: bin_a_bcd.
  - Sequential double dabble with ports cargar, valor, listo, bcd[4*N_DIG-1:0].
  - Completes in ANCHO cycles.
- The top level keeps the FSM, the leading-zero index finder and the output register.

Test Plan:
1. reset, then inicio with valor=1234, negativo=0, acepta held 1 -> valido rises 21 cycles after inicio; digits 1,2,3,4 on consecutive cycles; fin one cycle after the last transfer; ocupado low with fin.
2. valor=0 -> exactly one digit 0, then fin.
3. valor=1048575, negativo=1, acepta toggling 1/0 each cycle -> codes 16,1,0,4,8,5,7,5 delivered in order; digito stable while acepta=0; no code duplicated or lost.
4. error=1 with valor=77, negativo=1 -> single code 17, no conversion delay (valido after edge 1), then fin.
5. inicio pulsed again during CONVIERTE and during EMITE -> ignored; output matches the first request only. inicio in the cycle after fin -> accepted.
6. reset asserted mid-EMITE after 2 of 4 digits -> next cycle valido=0, ocupado=0, no fin. A new inicio with valor=5 -> emits 5 cleanly.
